// File: rtl/digit_overlay_ctrl_pkg.sv
// Shared constants, FSM state type and glyph helpers for the numeric overlay.
package digit_overlay_ctrl_pkg;

    localparam int unsigned DIGIT_W    = 16;
    localparam int unsigned DIGIT_H    = 32;
    localparam int unsigned GLYPH_BITS = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    // Glyph MSB is the top-left pixel, so the bit index runs backwards.
    function automatic logic [8:0] glyph_addr_of(input logic [4:0] row, input logic [3:0] col);
        return 9'(GLYPH_BITS - 1) - {row, col};
    endfunction

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/digit_overlay_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle after start.
module bin2bcd_seq
    import digit_overlay_ctrl_pkg::*;
#(
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VAL_W-1:0]        data,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    logic [VAL_W-1:0] bin;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            bcd_adj[4*k +: 4] = add3_if_ge5(bcd[4*k +: 4]);
        end
    end

    // High during the final shift, so bcd holds the result on the next cycle.
    assign done = running && (cnt == CNT_W'(VAL_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            bin     <= data;
            bcd     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            bcd <= {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
            bin <= bin << 1;
            cnt <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/digit_overlay_ctrl.sv
// Frame-synchronous numeric overlay sequencer feeding the 16x32 decimal glyph ROM.
module digit_overlay_ctrl
    import digit_overlay_ctrl_pkg::*;
#(
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [VAL_W-1:0] value,
    input  logic             value_valid,
    input  logic [11:0]      pixel_x,
    input  logic [11:0]      pixel_y,
    input  logic             de,
    output logic [3:0]       number_data,
    output logic [8:0]       glyph_addr,
    output logic             overlay_en,
    output logic             busy
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [11:0] FIELD_W = 12'(DIGIT_W * NUM_DIGITS);
    localparam logic [11:0] FIELD_H = 12'(DIGIT_H);

    state_t                  state;
    logic [VAL_W-1:0]        shadow;
    logic [3:0]              digits [NUM_DIGITS];
    logic                    conv_start;
    logic                    conv_done;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (value_valid) begin
            shadow <= value;
        end
    end

    assign conv_start = (state == S_LOAD);

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .data  (shadow),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                digits[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD:  state <= S_SHIFT;
                S_SHIFT: begin
                    if (conv_done) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // digits[0] is the most significant, i.e. the top BCD nibble.
                    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                        digits[k] <= conv_bcd[4*(NUM_DIGITS-1-k) +: 4];
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [11:0]           dx;
    logic [11:0]           dy;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] vis;
    logic                  seen;
    logic [3:0]            sel_digit;
    logic                  sel_vis;

    // Left/above the field wraps dx/dy to large values, so one compare per axis suffices.
    assign dx  = pixel_x - 12'(X0);
    assign dy  = pixel_y - 12'(Y0);
    assign hit = de && (dx < FIELD_W) && (dy < FIELD_H);
    assign idx = dx[4 +: IDX_W];

    always_comb begin
        seen      = 1'b0;
        vis       = '0;
        sel_digit = '0;
        sel_vis   = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            seen   = seen | (digits[k] != 4'd0);
            vis[k] = seen | (k == NUM_DIGITS - 1);
            if (idx == IDX_W'(k)) begin
                sel_digit = digits[k];
                sel_vis   = vis[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_data <= '0;
            glyph_addr  <= '0;
            overlay_en  <= 1'b0;
        end else begin
            number_data <= hit ? sel_digit : 4'd0;
            glyph_addr  <= hit ? glyph_addr_of(dy[4:0], dx[3:0]) : 9'd0;
            overlay_en  <= hit && sel_vis;
        end
    end

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Directed scoreboard bench for digit_overlay_ctrl with a decimal reference model.
module tb_digit_overlay_ctrl;

    localparam int VAL_W = 16;
    localparam int N     = 5;
    localparam int X0    = 0;
    localparam int Y0    = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start;
    logic [VAL_W-1:0] value;
    logic             value_valid;
    logic [11:0]      pixel_x;
    logic [11:0]      pixel_y;
    logic             de;
    logic [3:0]       number_data;
    logic [8:0]       glyph_addr;
    logic             overlay_en;
    logic             busy;

    typedef struct {
        int nd;
        int ga;
        bit en;
        bit ga_care;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned shown  = 0;

    digit_overlay_ctrl #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (N),
        .X0         (X0),
        .Y0         (Y0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .value       (value),
        .value_valid (value_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .de          (de),
        .number_data (number_data),
        .glyph_addr  (glyph_addr),
        .overlay_en  (overlay_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: digits by decimal division, blanking by magnitude.
    function automatic exp_t model(input int unsigned v, input int x, input int y, input bit d);
        exp_t e;
        int   dx, dy, k, pw;
        e.nd = 0; e.ga = 0; e.en = 1'b0; e.ga_care = 1'b0;
        dx = x - X0;
        dy = y - Y0;
        if (d && dx >= 0 && dx < 16 * N && dy >= 0 && dy < 32) begin
            k  = dx / 16;
            pw = 1;
            for (int i = 0; i < N - 1 - k; i++) pw = pw * 10;
            e.nd      = int'((v / pw) % 10);
            e.en      = (v >= pw) || (k == N - 1);
            e.ga      = 511 - (dy * 16 + dx % 16);
            e.ga_care = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pix(input int x, input int y, input bit d);
        exp_t e;
        pixel_x = 12'(x);
        pixel_y = 12'(y);
        de      = d;
        sb.push_back(model(shown, x, y, d));
        tick();
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("number_data", 32'(number_data), 32'(e.nd));
            chk("overlay_en", 32'(overlay_en), 32'(e.en));
            if (e.ga_care) chk("glyph_addr", 32'(glyph_addr), 32'(e.ga));
        end
    endtask

    task automatic check_digits();
        for (int k = 0; k < N; k++) check_pix(X0 + 16 * k + 5, Y0 + 12, 1'b1);
        de = 1'b0;
    endtask

    task automatic load_value(input int unsigned v);
        value       = VAL_W'(v);
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic convert(input int unsigned v);
        int n;
        load_value(v);
        pulse_frame();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            tick();
        end
        chk("busy_cycles", 32'(n), 32'd18);
        chk("busy_end", 32'(busy), 32'd0);
        shown = v;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        value       = '0;
        value_valid = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        de          = 1'b0;
        repeat (3) tick();
        chk("rst_number_data", 32'(number_data), 32'd0);
        chk("rst_glyph_addr", 32'(glyph_addr), 32'd0);
        chk("rst_overlay_en", 32'(overlay_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Before any conversion the field shows a single 0.
        check_digits();

        convert(12345);
        check_digits();

        convert(0);
        for (int dx = 0; dx < 96; dx++) check_pix(X0 + dx, Y0 + 3, 1'b1);

        convert(305);
        check_pix(X0 + 35, Y0 + 5, 1'b1);
        check_pix(X0 + 35, Y0 + 5, 1'b0);
        check_pix(X0 + 79, Y0 + 31, 1'b1);

        convert(65535);
        check_digits();
        check_pix(X0 + 80, Y0 + 5, 1'b1);
        check_pix(X0 + 10, Y0 + 32, 1'b1);
        check_pix(X0 + 10, Y0 - 1, 1'b1);
        check_pix(X0, Y0, 1'b1);

        // New value and extra frame_start during a conversion.
        load_value(777);
        pulse_frame();
        repeat (5) tick();
        load_value(42);
        pulse_frame();
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            chk("no_retrigger", 32'(busy), 32'd0);
            tick();
        end
        shown = 777;
        check_digits();
        convert(42);
        check_digits();

        // Reset mid-conversion.
        load_value(999);
        pulse_frame();
        repeat (9) tick();
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_number_data", 32'(number_data), 32'd0);
        chk("arst_glyph_addr", 32'(glyph_addr), 32'd0);
        chk("arst_overlay_en", 32'(overlay_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        shown = 0;
        repeat (25) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_digits();
        convert(88);
        check_digits();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
